// File: rtl/window_result_writer_if.sv
// window_result_writer_if
//   Handshake and RAM write-port bundle between the window result source,
//   the window slider and the result writer.
//   master: drives start / res_bit / res_valid, observes everything else.
//   slave : the writer; accepts results, drives slide, RAM write port,
//           busy and done.
interface window_result_writer_if #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DATA_ADDR_WIDTH = 10
);
    logic                       start;
    logic                       res_bit;
    logic                       res_valid;
    logic                       res_ready;
    logic                       slide;
    logic [DATA_ADDR_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0]      ram_w_data;
    logic                       ram_w_en;
    logic                       busy;
    logic                       done;

    modport master (
        output start, res_bit, res_valid,
        input  res_ready, slide, ram_w_addr, ram_w_data, ram_w_en, busy, done
    );

    modport slave (
        input  start, res_bit, res_valid,
        output res_ready, slide, ram_w_addr, ram_w_data, ram_w_en, busy, done
    );
endinterface

// File: rtl/window_result_writer.sv
// window_result_writer
//   Write-back end of the binary window datapath. Collects one result bit
//   per kernel window and stores the output feature map row-major into a
//   single-port RAM starting at BASE_ADDR, requesting the next window from
//   the slider with a one-cycle slide pulse after each accepted result.
//
//   Optional feature macro: WINDOW_WRITER_PACK_EN
//     defined   : DATA_WIDTH results packed per word, LSB first.
//     undefined : one result per word (bit 0, upper bits zero), the format
//                 the window-slide reader consumes.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous reset, active low
//     bus  - window_result_writer_if.slave
//              start      in  : begin a new map (sampled in IDLE only)
//              res_bit    in  : window result
//              res_valid  in  : res_bit valid
//              res_ready  out : result accepted when res_valid & res_ready
//              slide      out : request next window (registered pulse)
//              ram_w_addr out : RAM write address
//              ram_w_data out : RAM write data
//              ram_w_en   out : RAM write strobe
//              busy       out : high outside IDLE
//              done       out : one-cycle pulse after the final write
module window_result_writer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DATA_ADDR_WIDTH = 10,
    parameter int unsigned IMAGE_ROW_LEN   = 32,
    parameter int unsigned IMAGE_COL_LEN   = 32,
    parameter int unsigned KERNEL_SIZE     = 3,
    parameter int unsigned STRIDE          = 1,
    parameter int unsigned BASE_ADDR       = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    window_result_writer_if.slave   bus
);
    localparam int unsigned OUT_ROWS = (IMAGE_ROW_LEN - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned OUT_COLS = (IMAGE_COL_LEN - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned TOTAL    = OUT_ROWS * OUT_COLS;
    localparam int unsigned N_W      = $clog2(TOTAL + 1);
`ifdef WINDOW_WRITER_PACK_EN
    localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [N_W-1:0]             n_q, n_d;
    logic [DATA_ADDR_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0]      wbuf_q, wbuf_d;
    logic                       slide_q, slide_d;
`ifdef WINDOW_WRITER_PACK_EN
    logic [BIT_W-1:0]           bit_q, bit_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            word_q  <= '0;
            wbuf_q  <= '0;
            slide_q <= 1'b0;
`ifdef WINDOW_WRITER_PACK_EN
            bit_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            wbuf_q  <= wbuf_d;
            slide_q <= slide_d;
`ifdef WINDOW_WRITER_PACK_EN
            bit_q   <= bit_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        wbuf_d  = wbuf_q;
        slide_d = 1'b0;
`ifdef WINDOW_WRITER_PACK_EN
        bit_d   = bit_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d     = '0;
                    word_d  = '0;
                    wbuf_d  = '0;
`ifdef WINDOW_WRITER_PACK_EN
                    bit_d   = '0;
`endif
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (bus.res_valid) begin
                    n_d     = n_q + 1'b1;
                    // The last window has no successor to slide to.
                    slide_d = (n_q != N_W'(TOTAL - 1));
`ifdef WINDOW_WRITER_PACK_EN
                    wbuf_d[bit_q] = bus.res_bit;
                    bit_d         = bit_q + 1'b1;
                    // Flush on a full word or on the final (possibly partial) word.
                    if (bit_q == BIT_W'(DATA_WIDTH - 1) || n_q == N_W'(TOTAL - 1)) begin
                        bit_d   = '0;
                        state_d = S_WRITE;
                    end
`else
                    wbuf_d    = '0;
                    wbuf_d[0] = bus.res_bit;
                    state_d   = S_WRITE;
`endif
                end
            end

            S_WRITE: begin
                word_d  = word_q + 1'b1;
                wbuf_d  = '0;
                state_d = (n_q == N_W'(TOTAL)) ? S_DONE : S_COLLECT;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.res_ready  = (state_q == S_COLLECT);
    assign bus.ram_w_en   = (state_q == S_WRITE);
    assign bus.ram_w_addr = DATA_ADDR_WIDTH'(BASE_ADDR) + word_q;
    assign bus.ram_w_data = wbuf_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.slide      = slide_q;

endmodule

// File: doc/window_result_writer.md
# window_result_writer

Write-back end of the binary window datapath. It consumes one result bit per kernel window from the downstream logic unit and stores the output feature map row-major into a single-port RAM. It issues the `slide` request that advances the window slider to the next window. It pairs with the window-slide reader: the reader fetches image bits from RAM, and this block writes the results back.

## Interface
- `DATA_WIDTH`, 8: RAM word width.
- `DATA_ADDR_WIDTH`, 10: RAM address width.
- `IMAGE_ROW_LEN`, 32: input image rows.
- `IMAGE_COL_LEN`, 32: input image columns.
- `KERNEL_SIZE`, 3: window edge.
- `STRIDE`, 1: window step.
- `BASE_ADDR`, 512: first RAM word of the output map.
- Derived values:
  - OUT_ROWS = (IMAGE_ROW_LEN-KERNEL_SIZE)/STRIDE+1.
  - OUT_COLS = (IMAGE_COL_LEN-KERNEL_SIZE)/STRIDE+1.
  - TOTAL = OUT_ROWS*OUT_COLS (900 at defaults).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a new map; sampled in IDLE only.
- `res_bit` in 1: window result.
- `res_valid` in 1: `res_bit` valid.
- `res_ready` out 1: writer can accept; a result transfers when `res_valid & res_ready`.
- `slide` out 1: one-cycle request to the slider for the next window.
- `ram_w_addr` out DATA_ADDR_WIDTH: write address.
- `ram_w_data` out DATA_WIDTH: write data.
- `ram_w_en` out 1: write strobe, one cycle per word.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse after the final word is written.

## Operation
States:
- IDLE: `res_ready`=0. On `start`, clear the result counter `n`, the word counter and the shift register, then go to COLLECT.
- COLLECT: `res_ready`=1. On transfer, place `res_bit` into the word buffer and increment `n`. Go to WRITE when:
  - the word fills, or
  - `n` reaches TOTAL with a partial word (unused high bits are zero).
  - Otherwise stay in COLLECT.
- WRITE: `res_ready`=0. Drive `ram_w_en`=1, `ram_w_addr`=BASE_ADDR+word_count, `ram_w_data`=buffer. Increment word_count and clear the buffer. Go to DONE if `n`==TOTAL, else to COLLECT.
- DONE: pulse `done`, go to IDLE.

Rules:
- Result n maps to word BASE_ADDR + n/DATA_WIDTH, bit n mod DATA_WIDTH (LSB first).
- `slide` is registered. It pulses the cycle after each transfer, except the transfer of result TOTAL-1. No slide is issued on `start`, because the first window comes from pipeline fill.
- `start` while busy is ignored. `res_valid` outside COLLECT is ignored.
- Address arithmetic is DATA_ADDR_WIDTH bits with wrap-around. The design must satisfy BASE_ADDR + ceil(TOTAL/DATA_WIDTH) ≤ 2^DATA_ADDR_WIDTH; the bench asserts this.
- Reset mid-operation: immediately return to IDLE, clear all counters and the buffer, issue no write and no `done`.

## Timing
- Reset values:
  - `res_ready`, `slide`, `ram_w_en`, `busy`, `done`: 0.
  - `ram_w_addr`: BASE_ADDR.
  - `ram_w_data`: 0.
- `start` at cycle t: `busy`=1 and `res_ready`=1 from t+1.
- Transfer at cycle t:
  - `slide`=1 at t+1.
  - If that transfer completes a word, `ram_w_en`=1 at t+1 and `res_ready` returns at t+2.
- Final write at cycle w: `done`=1 at w+1, then `busy`=0 at w+2.
- Throughput:
  - Packed: DATA_WIDTH results per DATA_WIDTH+1 cycles.
  - Unpacked: one result per 2 cycles.

## Configuration
- `WINDOW_WRITER_PACK_EN` defined: results are packed DATA_WIDTH per word as above. Defaults give 113 words; the last word holds 4 valid bits (900 mod 8).
- Undefined: every result is written to its own word at BASE_ADDR+n, in bit 0 with upper bits zero. This is the format the window-slide reader consumes, so maps can be chained. Each transfer triggers WRITE; defaults give 900 words.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 -> all outputs at their reset values, no `ram_w_en`.
- Packed, defaults: `start`, then stream 900 results with `res_valid` held high and `res_bit`=n[0] -> 113 writes at addresses 512..624, data 8'hAA, last word 8'h0A. Also:
  - 899 `slide` pulses.
  - `done` one cycle after the write to 624.
- Unpacked (macro off): stream 5 results 1,0,1,1,0 -> writes at 512..516 with data 1,0,1,1,0; `res_ready` low on every WRITE cycle.
- Backpressure/gaps: randomly deassert `res_valid` with `res_bit`=1 -> same write count and addresses, all words 8'hFF except the last (8'h0F); no `slide` without a transfer.
- Reset mid-map: assert `rst`=0 after 50 transfers -> IDLE next cycle. A new `start` restarts with the first write at 512.
- `start` while busy: pulse `start` at transfer 20 -> ignored; counters continue, with exactly 113 writes total.
